// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall sequencer.
package pipe_pkg;

   localparam int unsigned LAT_W_DEF = 4;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      FP_BUSY = 2'd1,
      FP_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/fp_lat_counter.sv
// Down-counter timing a multi-cycle FP operation; o_tc flags the decrement that reaches 1.
module fp_lat_counter
   import pipe_pkg::*;
#(
   parameter int unsigned LAT_W = LAT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [LAT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_tc
);

   logic [LAT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - LAT_W'(1);
      end
   end

   // A load value of 1 (latency 2) is already terminal, so <= 2 rather than == 2.
   assign o_tc = (r_cnt <= LAT_W'(2));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall sequencer driving every pipeline register write enable and nop strobe.
// Optional build macro STALL_CNT_EN adds a saturating stall-cycle counter.
module pipe_stall_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned LAT_W = LAT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef STALL_CNT_EN
   input  logic             stallCntClr,
   output logic [31:0]      stallCycles,
`endif
   input  logic             loadUseHazard,
   input  logic             branchTaken,
   input  logic             fpOpStart,
   input  logic [LAT_W-1:0] fpOpLatency,
   input  logic             memReq,
   input  logic             memReady,
   output logic             writePc,
   output logic             writeIfId,
   output logic             writeIdEx,
   output logic             writeExMem,
   output logic             writeMemWb,
   output logic             flushIfId,
   output logic             bubbleIdEx,
   output logic             bubbleExMem,
   output logic             fpBusy,
   output logic             fpDone
);

   state_e r_state;
   logic   w_mem_stall;
   logic   w_fp_issue;
   logic   w_fp_load;
   logic   w_fp_tc;

   assign w_mem_stall = memReq & ~memReady;
   assign w_fp_issue  = fpOpStart && (fpOpLatency >= LAT_W'(2));
   assign w_fp_load   = (r_state == RUN) && !w_mem_stall && w_fp_issue;

   fp_lat_counter #(
      .LAT_W (LAT_W)
   ) u_fp_lat_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_fp_load),
      .i_load_val (fpOpLatency - LAT_W'(1)),
      .i_dec      (r_state == FP_BUSY),
      .o_tc       (w_fp_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
      end else begin
         case (r_state)
            RUN:     if (w_fp_load) r_state <= FP_BUSY;
            FP_BUSY: if (w_fp_tc) r_state <= FP_DONE;
            FP_DONE: if (!w_mem_stall) r_state <= RUN;
            default: r_state <= RUN;
         endcase
      end
   end

   always_comb begin
      writePc     = 1'b0;
      writeIfId   = 1'b0;
      writeIdEx   = 1'b0;
      writeExMem  = 1'b0;
      writeMemWb  = 1'b0;
      flushIfId   = 1'b0;
      bubbleIdEx  = 1'b0;
      bubbleExMem = 1'b0;
      fpBusy      = 1'b0;
      fpDone      = 1'b0;
      if (rst_n) begin
         case (r_state)
            RUN: begin
               writePc    = 1'b1;
               writeIfId  = 1'b1;
               writeIdEx  = 1'b1;
               writeExMem = 1'b1;
               writeMemWb = 1'b1;
               if (!w_fp_issue) begin
                  if (loadUseHazard) begin
                     writePc    = 1'b0;
                     writeIfId  = 1'b0;
                     bubbleIdEx = 1'b1;
                  end else if (branchTaken) begin
                     flushIfId  = 1'b1;
                     bubbleIdEx = 1'b1;
                  end
               end
            end
            FP_BUSY: begin
               fpBusy      = 1'b1;
               writeExMem  = 1'b1;
               writeMemWb  = 1'b1;
               bubbleExMem = 1'b1;
            end
            FP_DONE: begin
               fpDone     = 1'b1;
               writePc    = 1'b1;
               writeIfId  = 1'b1;
               writeIdEx  = 1'b1;
               writeExMem = 1'b1;
               writeMemWb = 1'b1;
            end
            default: ;
         endcase
         // A data-memory wait freezes every register and hides all strobes in any state.
         if (w_mem_stall) begin
            writePc     = 1'b0;
            writeIfId   = 1'b0;
            writeIdEx   = 1'b0;
            writeExMem  = 1'b0;
            writeMemWb  = 1'b0;
            flushIfId   = 1'b0;
            bubbleIdEx  = 1'b0;
            bubbleExMem = 1'b0;
         end
      end
   end

`ifdef STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (stallCntClr) begin
         r_stall_cnt <= '0;
      end else if (!writePc && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stallCycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: vector table plus reset/stall-counter sequences.
module tb_pipe_stall_ctrl;

   localparam int unsigned LAT_W = 4;

   // Output bit order: writePc writeIfId writeIdEx writeExMem writeMemWb
   //                   flushIfId bubbleIdEx bubbleExMem fpBusy fpDone
   localparam logic [9:0] E_RUN     = 10'b11111_00000;
   localparam logic [9:0] E_LU      = 10'b00111_01000;
   localparam logic [9:0] E_BR      = 10'b11111_11000;
   localparam logic [9:0] E_STALL   = 10'b00000_00000;
   localparam logic [9:0] E_BUSY    = 10'b00011_00110;
   localparam logic [9:0] E_BUSY_MS = 10'b00000_00010;
   localparam logic [9:0] E_DONE    = 10'b11111_00001;
   localparam logic [9:0] E_DONE_MS = 10'b00000_00001;
   localparam logic [9:0] E_ZERO    = 10'b00000_00000;

   typedef struct packed {
      logic [8:0] in;
      logic [9:0] exp;
   } vec_t;

   localparam int NV = 36;

   logic             clk;
   logic             rst_n;
   logic             loadUseHazard;
   logic             branchTaken;
   logic             fpOpStart;
   logic [LAT_W-1:0] fpOpLatency;
   logic             memReq;
   logic             memReady;
   logic             writePc, writeIfId, writeIdEx, writeExMem, writeMemWb;
   logic             flushIfId, bubbleIdEx, bubbleExMem, fpBusy, fpDone;
   logic [9:0]       act;
`ifdef STALL_CNT_EN
   logic             stallCntClr;
   logic [31:0]      stallCycles;
   logic [31:0]      exp_stall;
`endif

   int         n_checks;
   int         n_fail;
   logic [9:0] exp_q[$];
   vec_t       vecs[NV];

   pipe_stall_ctrl #(
      .LAT_W (LAT_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
`ifdef STALL_CNT_EN
      .stallCntClr   (stallCntClr),
      .stallCycles   (stallCycles),
`endif
      .loadUseHazard (loadUseHazard),
      .branchTaken   (branchTaken),
      .fpOpStart     (fpOpStart),
      .fpOpLatency   (fpOpLatency),
      .memReq        (memReq),
      .memReady      (memReady),
      .writePc       (writePc),
      .writeIfId     (writeIfId),
      .writeIdEx     (writeIdEx),
      .writeExMem    (writeExMem),
      .writeMemWb    (writeMemWb),
      .flushIfId     (flushIfId),
      .bubbleIdEx    (bubbleIdEx),
      .bubbleExMem   (bubbleExMem),
      .fpBusy        (fpBusy),
      .fpDone        (fpDone)
   );

   assign act = {writePc, writeIfId, writeIdEx, writeExMem, writeMemWb,
                 flushIfId, bubbleIdEx, bubbleExMem, fpBusy, fpDone};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [8:0] mi(input bit lu, input bit br, input bit fs, input int lat,
                                     input bit mreq, input bit mrdy);
      logic [3:0] l;
      l = 4'(lat);
      return {lu, br, fs, l, mreq, mrdy};
   endfunction

   task automatic check(input string name);
      logic [9:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (act !== e) begin
         n_fail++;
         $display("FAIL %s: outputs got %b expected %b", name, act, e);
      end
`ifdef STALL_CNT_EN
      n_checks++;
      if (stallCycles !== exp_stall) begin
         n_fail++;
         $display("FAIL %s_stallcnt: got %0d expected %0d", name, stallCycles, exp_stall);
      end
      if (stallCntClr) exp_stall = 32'd0;
      else if (!e[9] && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
`endif
   endtask

   // Called just after a rising edge; returns just after the next rising edge.
   task automatic step(input logic [8:0] in, input logic [9:0] exp, input string name);
      {loadUseHazard, branchTaken, fpOpStart, fpOpLatency, memReq, memReady} = in;
      exp_q.push_back(exp);
      @(negedge clk);
      check(name);
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      vecs[0]  = '{mi(0,0,0,0,0,0), E_RUN};
      vecs[1]  = '{mi(0,0,0,0,0,0), E_RUN};
      vecs[2]  = '{mi(0,0,0,0,0,0), E_RUN};
      vecs[3]  = '{mi(0,0,0,0,0,0), E_RUN};
      vecs[4]  = '{mi(0,0,0,0,0,0), E_RUN};
      vecs[5]  = '{mi(0,0,1,4,0,0), E_RUN};      // FP issue, latency 4
      vecs[6]  = '{mi(0,0,0,0,0,0), E_BUSY};
      vecs[7]  = '{mi(1,1,0,0,0,0), E_BUSY};     // hazards ignored while busy
      vecs[8]  = '{mi(0,0,0,0,0,0), E_DONE};
      vecs[9]  = '{mi(0,0,0,0,0,0), E_RUN};
      vecs[10] = '{mi(1,0,0,0,0,0), E_LU};
      vecs[11] = '{mi(0,1,0,0,0,0), E_BR};
      vecs[12] = '{mi(1,1,0,0,0,0), E_LU};
      vecs[13] = '{mi(0,1,1,1,0,0), E_BR};      // latency 1 is single-cycle
      vecs[14] = '{mi(0,0,0,0,1,0), E_STALL};
      vecs[15] = '{mi(0,0,0,0,1,0), E_STALL};
      vecs[16] = '{mi(0,0,0,0,1,0), E_STALL};
      vecs[17] = '{mi(0,0,0,0,1,1), E_RUN};
      vecs[18] = '{mi(1,0,0,0,1,0), E_STALL};
      vecs[19] = '{mi(1,0,0,0,0,0), E_LU};
      vecs[20] = '{mi(0,0,1,6,0,0), E_RUN};      // FP issue, latency 6
      vecs[21] = '{mi(0,0,0,0,0,0), E_BUSY};
      vecs[22] = '{mi(0,0,0,0,1,0), E_BUSY_MS};
      vecs[23] = '{mi(0,0,0,0,1,0), E_BUSY_MS};
      vecs[24] = '{mi(1,1,0,0,0,0), E_BUSY};
      vecs[25] = '{mi(0,0,0,0,1,0), E_DONE_MS};  // issue + 5: done despite stalls
      vecs[26] = '{mi(0,0,0,0,0,0), E_DONE};
      vecs[27] = '{mi(0,0,0,0,0,0), E_RUN};
      vecs[28] = '{mi(0,0,1,0,0,0), E_RUN};
      vecs[29] = '{mi(0,0,0,0,0,0), E_RUN};
      vecs[30] = '{mi(0,0,1,2,0,0), E_RUN};      // latency 2
      vecs[31] = '{mi(0,0,0,0,0,0), E_BUSY};
      vecs[32] = '{mi(0,0,0,0,0,0), E_DONE};
      vecs[33] = '{mi(0,0,0,0,0,0), E_RUN};
      vecs[34] = '{mi(0,0,1,4,1,0), E_STALL};    // issue blocked by memory wait
      vecs[35] = '{mi(0,0,0,0,0,0), E_RUN};

      rst_n = 1'b0;
      {loadUseHazard, branchTaken, fpOpStart, fpOpLatency, memReq, memReady} = '0;
`ifdef STALL_CNT_EN
      stallCntClr = 1'b0;
      exp_stall   = 32'd0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      exp_q.push_back(E_ZERO);
      check("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         step(vecs[i].in, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Asynchronous reset in the middle of FP_BUSY.
      step(mi(0,0,1,6,0,0), E_RUN, "rst_issue");
      step(mi(0,0,0,0,0,0), E_BUSY, "rst_busy0");
      {loadUseHazard, branchTaken, fpOpStart, fpOpLatency, memReq, memReady} = '0;
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.push_back(E_ZERO);
      check("rst_async");
`ifdef STALL_CNT_EN
      exp_stall = 32'd0;
`endif
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) begin
         step(mi(0,0,0,0,0,0), E_RUN, $sformatf("post_rst%0d", i));
      end

`ifdef STALL_CNT_EN
      step(mi(1,0,0,0,0,0), E_LU, "cnt_lu");
      step(mi(0,0,0,0,1,0), E_STALL, "cnt_ms");
      stallCntClr = 1'b1;
      step(mi(0,0,0,0,0,0), E_RUN, "cnt_clr");
      stallCntClr = 1'b0;
      step(mi(0,0,0,0,0,0), E_RUN, "cnt_after_clr");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
